// File: rtl/cmp_share_arb.sv
// Round-robin sequencer sharing one registered magnitude comparator among NREQ
// requesters; tags each issued compare and routes its result back to the issuer.
module cmp_share_arb #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int CMP_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      cmp_a,
  output logic [WIDTH-1:0]      cmp_b,
  output logic                  cmp_issue,
  input  logic                  cmp_gt,
  input  logic                  cmp_lt,
  input  logic                  cmp_eq,
  output logic [NREQ-1:0]       rsp_valid,
  output logic                  rsp_gt,
  output logic                  rsp_lt,
  output logic                  rsp_eq,
  output logic                  busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    cand;
  logic             gnt_any;
  logic [NREQ-1:0]  pending;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  retire;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             tag_vld_p [CMP_LAT+1];
  logic [IW-1:0]    tag_idx_p [CMP_LAT+1];

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return IW'(s % NREQ);
  endfunction

  assign elig = req_valid & ~pending;
  assign busy = |pending;

  // Arbitration: first eligible index scanning upward from ptr
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = wrap_add(ptr, j);
      if (!gnt_any && elig[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_a = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_b = req_b[int'(gnt_idx)*WIDTH +: WIDTH];

  always_comb begin
    retire = '0;
    if (tag_vld_p[CMP_LAT]) retire[tag_idx_p[CMP_LAT]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      pending   <= '0;
      cmp_issue <= 1'b0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      rsp_valid <= '0;
      rsp_gt    <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_eq    <= 1'b0;
      for (int s = 0; s <= CMP_LAT; s++) begin
        tag_vld_p[s] <= 1'b0;
        tag_idx_p[s] <= '0;
      end
    end else begin
      if (gnt_any) ptr <= wrap_add(gnt_idx, 1);
      pending <= (pending & ~retire) | req_ready;
      // Stage p0: operands launched to the comparator alongside the tag head
      cmp_issue    <= gnt_any;
      tag_vld_p[0] <= gnt_any;
      tag_idx_p[0] <= gnt_idx;
      if (gnt_any) begin
        cmp_a <= sel_a;
        cmp_b <= sel_b;
      end
      // Stages p1..pCMP_LAT: tag follows the comparator pipeline
      for (int s = 1; s <= CMP_LAT; s++) begin
        tag_vld_p[s] <= tag_vld_p[s-1];
        tag_idx_p[s] <= tag_idx_p[s-1];
      end
      // Tail: comparator result is valid now; route it to the tagged requester
      rsp_valid <= retire;
      if (tag_vld_p[CMP_LAT]) begin
        rsp_gt <= cmp_gt;
        rsp_lt <= cmp_lt;
        rsp_eq <= cmp_eq;
      end
    end
  end
endmodule
